// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared types and constants for the auto-baud controller
package baud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_FALL,
    MEASURE,
    CALC,
    WAIT_STOP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_RANGE    = 2'd3
  } err_t;

  localparam int OVS_LOG2       = 4;
  localparam int SYNC_EDGES     = 9;
  localparam int BIT_TIMES_LOG2 = 3;

endpackage

// File: rtl/rx_edge_det.sv
// rtl/rx_edge_det.sv - 2-FF synchronizer for the raw rx pin with registered edge pulses
module rx_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;

  // Edge pulses come from the first/second stage pair so they line up with level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= rx;
      level <= s1;
      rise  <= s1 & ~level;
      fall  <= ~s1 & level;
    end
  end

endmodule

// File: rtl/baud_autodetect.sv
// rtl/baud_autodetect.sv - measures a 0x55 sync character and programs the baud_gen divisor
module baud_autodetect
  import baud_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DVSR_W       = 11,
  parameter int DVSR_DEFAULT = 650
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic [DVSR_W-1:0] dvsr,
  output logic              locked,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int SUMW  = CNT_W + 1;
  localparam int SHIFT = OVS_LOG2 + BIT_TIMES_LOG2;
  localparam logic [CNT_W:0] DVSR_MAX = SUMW'((1 << DVSR_W) - 1);

  logic rx_lvl, rx_rise, rx_fall;

  rx_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .level (rx_lvl),
    .rise  (rx_rise),
    .fall  (rx_fall)
  );

  state_t            state, state_n;
  err_t              code, code_n;
  logic [CNT_W-1:0]  c, c_n, i, i_n, w, w_n, ivl;
  logic [3:0]        edge_cnt, edge_n;
  logic [DVSR_W-1:0] pend, pend_n, dvsr_q, dvsr_n;
  logic              locked_q, locked_n, err_q, err_n;
  logic [CNT_W:0]    sum, q, q_m1;
  logic [CNT_W+1:0]  twice_i, three_w;
  logic              ivl_bad, range_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      code     <= ERR_NONE;
      c        <= '0;
      i        <= '0;
      w        <= '0;
      edge_cnt <= '0;
      pend     <= '0;
      dvsr_q   <= DVSR_W'(DVSR_DEFAULT);
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      c        <= c_n;
      i        <= i_n;
      w        <= w_n;
      edge_cnt <= edge_n;
      pend     <= pend_n;
      dvsr_q   <= dvsr_n;
      locked_q <= locked_n;
      err_q    <= err_n;
    end
  end

  // Interval includes the current cycle, so it equals the true edge spacing.
  assign ivl       = i + 1'b1;
  assign twice_i   = {1'b0, ivl, 1'b0};
  assign three_w   = {2'b00, w} + {1'b0, w, 1'b0};
  assign ivl_bad   = (twice_i < {2'b00, w}) || (twice_i > three_w);
  assign sum       = {1'b0, c} + SUMW'(1 << (SHIFT - 1));
  assign q         = sum >> SHIFT;
  assign q_m1      = q - SUMW'(1);
  assign range_bad = (q < SUMW'(2)) || (q_m1 > DVSR_MAX);

  always_comb begin
    state_n  = state;
    code_n   = code;
    c_n      = c;
    i_n      = i;
    w_n      = w;
    edge_n   = edge_cnt;
    pend_n   = pend;
    dvsr_n   = dvsr_q;
    locked_n = locked_q;
    err_n    = err_q;
    if (start) begin
      state_n  = ARM;
      c_n      = '0;
      i_n      = '0;
      edge_n   = '0;
      locked_n = 1'b0;
      err_n    = 1'b0;
      code_n   = ERR_NONE;
    end else begin
      case (state)
        ARM: if (rx_lvl) state_n = WAIT_FALL;
        WAIT_FALL: if (rx_fall) begin
          state_n = MEASURE;
          c_n     = '0;
          i_n     = '0;
          edge_n  = 4'd1;
        end
        MEASURE: begin
          if (c == '1 || i == '1) begin
            state_n = IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
          end else begin
            c_n = c + 1'b1;
            i_n = i + 1'b1;
            if (rx_rise || rx_fall) begin
              i_n    = '0;
              edge_n = edge_cnt + 4'd1;
              if (edge_cnt == 4'd1) begin
                w_n = ivl;
              end else if (ivl_bad) begin
                state_n = IDLE;
                err_n   = 1'b1;
                code_n  = ERR_MISMATCH;
              end else if (edge_cnt + 4'd1 == 4'(SYNC_EDGES)) begin
                state_n = CALC;
              end
            end
          end
        end
        CALC: begin
          i_n = i + 1'b1;
          if (range_bad) begin
            state_n = IDLE;
            err_n   = 1'b1;
            code_n  = ERR_RANGE;
          end else begin
            pend_n  = q_m1[DVSR_W-1:0];
            state_n = WAIT_STOP;
          end
        end
        WAIT_STOP: begin
          if (rx_rise) begin
            dvsr_n   = pend;
            locked_n = 1'b1;
            state_n  = IDLE;
          end else if (i == '1) begin
            state_n = IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
          end else begin
            i_n = i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dvsr     = dvsr_q;
  assign locked   = locked_q;
  assign busy     = (state != IDLE);
  assign err      = err_q;
  assign err_code = code;

endmodule

// File: tb/tb_baud_autodetect.sv
// tb/tb_baud_autodetect.sv - directed bench for the auto-baud controller
module tb_baud_autodetect;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        rx = 1'b1;
  logic [10:0] dvsr, dvsr2;
  logic        locked, busy, err, locked2, busy2, err2;
  logic [1:0]  err_code, err_code2;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  sync_byte = 8'h55;

  always #5 clk = ~clk;

  baud_autodetect dut (
    .clk(clk), .reset(reset), .start(start), .rx(rx), .dvsr(dvsr),
    .locked(locked), .busy(busy), .err(err), .err_code(err_code)
  );

  // Narrow counters so the saturation timeout is reachable quickly.
  baud_autodetect #(.CNT_W(10)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .rx(rx), .dvsr(dvsr2),
    .locked(locked2), .busy(busy2), .err(err2), .err_code(err_code2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int t, input bit stretch3, input bit stop);
    rx = 1'b0;
    repeat (t) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx = sync_byte[b];
      repeat ((stretch3 && b == 3) ? (t * 5) / 2 : t) @(negedge clk);
    end
    if (stop) rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dvsr", dvsr, 650);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);

    pulse_start();
    check("mm_busy", busy, 1);
    send_frame(160, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("mm_err", err, 1);
    check("mm_code", err_code, 2);
    check("mm_dvsr", dvsr, 650);
    check("mm_locked", locked, 0);
    check("mm_busy_end", busy, 0);

    pulse_start();
    check("rg_err_clr", err, 0);
    send_frame(8, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("rg_err", err, 1);
    check("rg_code", err_code, 3);
    check("rg_dvsr", dvsr, 650);

    pulse_start();
    send_frame(160, 1'b0, 1'b0);
    check("c160_prelock", locked, 0);
    check("c160_busy", busy, 1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("c160_locked", locked, 1);
    check("c160_dvsr", dvsr, 9);
    check("c160_busy_end", busy, 0);
    check("c160_err", err, 0);
    check("c160_code", err_code, 0);

    pulse_start();
    rx = 1'b0;
    repeat (160) @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check("mr_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mr_dvsr", dvsr, 650);
    check("mr_locked", locked, 0);
    check("mr_busy_rst", busy, 0);
    check("mr_err", err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    pulse_start();
    rx = 1'b0;
    repeat (160) @(negedge clk);
    rx = 1'b1;
    repeat (160) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx = 1'b1;
    check("cs_busy", busy, 1);
    check("cs_err", err, 0);
    repeat (50) @(negedge clk);
    send_frame(160, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("cs_locked", locked, 1);
    check("cs_dvsr", dvsr, 9);
    check("cs_err_end", err, 0);

    pulse_start();
    send_frame(10416, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("slow_locked", locked, 1);
    check("slow_dvsr", dvsr, 650);
    check("slow_err", err, 0);

    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b0;
    repeat (1100) @(negedge clk);
    check("to_err", err2, 1);
    check("to_code", err_code2, 1);
    check("to_busy", busy2, 0);
    check("to_dvsr", dvsr2, 650);
    check("to_main_idle", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_autodetect.md
Name: baud_autodetect

Overview:
- Auto-baud controller that programs the divisor of the UART baud-tick generator (`dvsr` input, 11 bits, tick period `dvsr+1` clocks, 16x oversampling).
- When armed by software, it measures an incoming sync character 0x55 ('U') on the raw rx line and computes the divisor.
- On success it drives the new divisor and asserts `locked`; on failure it keeps the previous divisor and flags an error.
- Sits between the rx pin, the CSR block, and `baud_gen`.

Parameters:
- CNT_W, 20, width of the measurement counters; saturation = timeout.
- DVSR_W, 11, divisor width; must match the `baud_gen` dvsr input.
- DVSR_DEFAULT, 650, divisor loaded at reset (9600 baud at 100 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; arms or re-arms detection
- rx  in  1  raw asynchronous serial line, idle high
- dvsr  out  DVSR_W  divisor to `baud_gen`
- locked  out  1  high once a valid divisor has been measured; cleared by start
- busy  out  1  high while not IDLE
- err  out  1  sticky failure flag; cleared by start
- err_code  out  2  0 none, 1 timeout, 2 interval mismatch, 3 result out of range

Behaviour:
- Reset values: `dvsr`=DVSR_DEFAULT, `locked`=0, `busy`=0, `err`=0, `err_code`=0, state IDLE.
- rx passes through a 2-FF synchronizer plus edge detector, giving 2 cycles of latency. All edge references below are detected edges on the synchronized signal.
- States:
  - IDLE: entered from reset, success or error. `start` -> ARM. `start` has priority in every state: it restarts at ARM, clears counters, `locked`, `err` and `err_code`, and leaves `dvsr` unchanged.
  - ARM: wait for synchronized rx == 1 (line idle), then -> WAIT_FALL. No timeout.
  - WAIT_FALL: first falling edge -> MEASURE. In that cycle, total counter C=0, interval counter I=0, edge count=1. No timeout.
  - MEASURE:
    - C and I increment every cycle.
    - On each edge: capture I as the interval, then reset I to 0.
    - The first interval (the start-bit width) is stored as W.
    - Each later interval I_k must satisfy 2*I_k >= W and 2*I_k <= 3*W; otherwise -> IDLE with `err`, code 2.
    - On the 9th edge (the 5th falling edge, i.e. exactly 8 bit times after the first) -> CALC with C frozen.
    - If C or I reaches all-ones -> IDLE with `err`, code 1.
  - CALC (1 cycle): q = (C + 64) >> 7.
    - If q < 2 or q - 1 > 2^DVSR_W - 1 -> IDLE with `err`, code 3.
    - Otherwise store q - 1 as the pending divisor -> WAIT_STOP.
  - WAIT_STOP: wait for the rising edge into the stop bit. On that edge, `dvsr` <= pending and `locked` <= 1 in the same cycle -> IDLE. I saturating here -> IDLE with `err`, code 1.
- `dvsr` changes only on lock or reset, never mid-measurement.
- `busy` = (state != IDLE).
- `start` in the same cycle as an edge: `start` wins and the edge is ignored.
- `reset` mid-operation: everything returns to reset values, including `dvsr`.

Decomposition:
- Package `baud_pkg`:
  - state enum (IDLE, ARM, WAIT_FALL, MEASURE, CALC, WAIT_STOP)
  - err_code enum (ERR_NONE, ERR_TIMEOUT, ERR_MISMATCH, ERR_RANGE)
  - constants: OVS_LOG2=4, SYNC_EDGES=9, BIT_TIMES_LOG2=3
- One sub-module, `rx_edge_det`: 2-FF synchronizer with registered rise/fall pulses and the synchronized level.

Test Plan:
- Reset -> `dvsr`=650, `locked`=0, `busy`=0, `err`=0. Reset asserted during MEASURE -> same values next cycle.
- `start`, then 0x55 at 160 clocks/bit -> C=1280, `dvsr`=9, `locked`=1 on the stop-bit rising edge plus 2 cycles, `busy`=0.
- `start`, then 0x55 at 10416 clocks/bit -> C=83328, `dvsr`=650, `locked`=1.
- `start`, then 0x55 with bit 3 stretched to 2.5x the bit time at 160 clocks/bit -> `err`=1, `err_code`=2, `dvsr` unchanged at 650, `locked`=0.
- `start`, one falling edge, then rx held low for 2^20 cycles -> `err_code`=1. Separately, 0x55 at 8 clocks/bit (C=64, q=1) -> `err_code`=3.
- Mid-MEASURE `start` pulse coincident with an edge -> returns to ARM, counters cleared. A subsequent clean 0x55 at 160 clocks/bit locks with `dvsr`=9.
